// File: rtl/traffic_pkg.sv
// Shared lamp encodings, fault codes and monitor states for the traffic-light safety stage.
package traffic_pkg;

    localparam logic [2:0] LED_RED = 3'b100;
    localparam logic [2:0] LED_GRN = 3'b010;
    localparam logic [2:0] LED_YEL = 3'b001;
    localparam logic [2:0] LED_OFF = 3'b000;

    typedef enum logic [2:0] {
        FC_NONE  = 3'd0,
        FC_ENC   = 3'd1,
        FC_CONF  = 3'd2,
        FC_SKIP  = 3'd3,
        FC_STUCK = 3'd4
    } fault_code_e;

    typedef enum logic [1:0] {
        MON     = 2'd0,
        FLASH   = 2'd1,
        RECOVER = 2'd2
    } mon_state_e;

    typedef logic [31:0] cnt_t;

    function automatic logic is_legal(input logic [2:0] code);
        return (code == LED_RED) || (code == LED_GRN) || (code == LED_YEL);
    endfunction

endpackage

// File: rtl/lamp_seq_check.sv
// Per-lamp checker: remembers last cycle's code and flags bad encodings and green->red skips.
module lamp_seq_check
    import traffic_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] code_i,
    output logic       is_green_o,
    output logic       is_red_o,
    output logic       bad_enc_o,
    output logic       skip_yel_o,
    output logic       changed_o
);

    logic [2:0] prev_q;

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) prev_q <= LED_RED;
        else        prev_q <= code_i;
    end

    assign is_green_o = (code_i == LED_GRN);
    assign is_red_o   = (code_i == LED_RED);
    assign bad_enc_o  = !is_legal(code_i);
    assign skip_yel_o = (prev_q == LED_GRN) && (code_i == LED_RED);
    assign changed_o  = (code_i != prev_q);

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Safety stage behind the street-light FSM: registered lamp pass-through, fault detection,
// flashing-red override until an operator clear, then a short solid-red recovery.
module traffic_conflict_monitor
    import traffic_pkg::*;
#(
    parameter int unsigned FILT_CYC    = 4,
    parameter int unsigned STUCK_CYC   = 200_000_000,
    parameter int unsigned BLINK_HALF  = 8_388_608,
    parameter int unsigned RECOVER_CYC = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] led_n_in,
    input  logic [2:0] led_e_in,
    input  logic [2:0] led_s_in,
    input  logic [2:0] led_w_in,
    input  logic [2:0] led_walk_in,
    input  logic       clear_fault,
    output logic [2:0] lamp_n,
    output logic [2:0] lamp_e,
    output logic [2:0] lamp_s,
    output logic [2:0] lamp_w,
    output logic [2:0] lamp_walk,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam int NLAMP = 5;  // 0..3 = N/E/S/W roads, 4 = walk

    logic [2:0]       code_in [NLAMP];
    logic [2:0]       lamp_q  [NLAMP];
    logic [NLAMP-1:0] is_green, is_red, bad_enc, skip_yel, changed;

    assign code_in[0] = led_n_in;
    assign code_in[1] = led_e_in;
    assign code_in[2] = led_s_in;
    assign code_in[3] = led_w_in;
    assign code_in[4] = led_walk_in;

    for (genvar i = 0; i < NLAMP; i++) begin : g_lamp
        lamp_seq_check u_chk (
            .clk        (clk),
            .rst_n      (rst_n),
            .code_i     (code_in[i]),
            .is_green_o (is_green[i]),
            .is_red_o   (is_red[i]),
            .bad_enc_o  (bad_enc[i]),
            .skip_yel_o (skip_yel[i]),
            .changed_o  (changed[i])
        );
    end

    logic v1, v2, v3, rearm;
    logic v1_fire, v2_fire, v4_fire;
    cnt_t enc_cnt_q, enc_cnt_d, conf_cnt_q, conf_cnt_d, stuck_cnt_q, stuck_cnt_d;
    cnt_t blink_cnt_q, rec_cnt_q;
    logic blink_off_q, fault_q;
    mon_state_e  state_q;
    fault_code_e fault_code_q, fire_code;

    assign v1 = |bad_enc;
    assign v2 = ($countones(is_green[3:0]) > 1) || (is_green[4] && !(&is_red[3:0]));
    assign v3 = |skip_yel;

    // A persistence filter fires on the cycle its counter would reach the threshold.
    assign v1_fire = v1 && (enc_cnt_q  >= FILT_CYC - 1);
    assign v2_fire = v2 && (conf_cnt_q >= FILT_CYC - 1);
    assign v4_fire = !(|changed) && (stuck_cnt_q >= STUCK_CYC - 1);
    assign rearm   = (state_q == FLASH) && clear_fault && !v1 && !v2 && !v3;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        fire_code   = FC_NONE;
        enc_cnt_d   = 32'd0;
        conf_cnt_d  = 32'd0;
        stuck_cnt_d = 32'd0;
        if      (v1_fire) fire_code = FC_ENC;
        else if (v2_fire) fire_code = FC_CONF;
        else if (v3)      fire_code = FC_SKIP;
        else if (v4_fire) fire_code = FC_STUCK;
        if (v1) enc_cnt_d  = (enc_cnt_q  == FILT_CYC)  ? enc_cnt_q  : enc_cnt_q  + 32'd1;
        if (v2) conf_cnt_d = (conf_cnt_q == FILT_CYC)  ? conf_cnt_q : conf_cnt_q + 32'd1;
        if (!rearm && !(|changed))
            stuck_cnt_d = (stuck_cnt_q == STUCK_CYC) ? stuck_cnt_q : stuck_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            enc_cnt_q   <= 32'd0;
            conf_cnt_q  <= 32'd0;
            stuck_cnt_q <= 32'd0;
        end else begin
            enc_cnt_q   <= enc_cnt_d;
            conf_cnt_q  <= conf_cnt_d;
            stuck_cnt_q <= stuck_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= MON;
            fault_q      <= 1'b0;
            fault_code_q <= FC_NONE;
            blink_cnt_q  <= 32'd0;
            blink_off_q  <= 1'b0;
            rec_cnt_q    <= 32'd0;
            for (int i = 0; i < NLAMP; i++) lamp_q[i] <= LED_RED;
        end else if (state_q != FLASH && fire_code != FC_NONE) begin
            // A new fault pre-empts both pass-through and an unfinished recovery.
            state_q      <= FLASH;
            fault_q      <= 1'b1;
            fault_code_q <= fire_code;
            blink_cnt_q  <= 32'd0;
            blink_off_q  <= 1'b0;
            for (int i = 0; i < NLAMP; i++) lamp_q[i] <= LED_RED;
        end else begin
            unique case (state_q)
                MON: begin
                    for (int i = 0; i < NLAMP; i++) lamp_q[i] <= code_in[i];
                end
                FLASH: begin
                    if (rearm) begin
                        state_q   <= RECOVER;
                        rec_cnt_q <= 32'd0;
                        for (int i = 0; i < NLAMP; i++) lamp_q[i] <= LED_RED;
                    end else if (blink_cnt_q == BLINK_HALF - 1) begin
                        blink_cnt_q <= 32'd0;
                        blink_off_q <= !blink_off_q;
                        for (int i = 0; i < 4; i++) lamp_q[i] <= blink_off_q ? LED_RED : LED_OFF;
                    end else begin
                        blink_cnt_q <= blink_cnt_q + 32'd1;
                    end
                end
                RECOVER: begin
                    if (rec_cnt_q == RECOVER_CYC - 1) begin
                        state_q      <= MON;
                        fault_q      <= 1'b0;
                        fault_code_q <= FC_NONE;
                        for (int i = 0; i < NLAMP; i++) lamp_q[i] <= code_in[i];
                    end else begin
                        rec_cnt_q <= rec_cnt_q + 32'd1;
                    end
                end
                default: state_q <= MON;
            endcase
        end
    end

    assign lamp_n     = lamp_q[0];
    assign lamp_e     = lamp_q[1];
    assign lamp_s     = lamp_q[2];
    assign lamp_w     = lamp_q[3];
    assign lamp_walk  = lamp_q[4];
    assign fault      = fault_q;
    assign fault_code = fault_code_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed bench for traffic_conflict_monitor with short filter, stuck, blink and recovery periods.
module tb_traffic_conflict_monitor;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] G = 3'b010;
    localparam logic [2:0] Y = 3'b001;
    localparam logic [2:0] O = 3'b000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] led_n_in, led_e_in, led_s_in, led_w_in, led_walk_in;
    logic       clear_fault;
    logic [2:0] lamp_n, lamp_e, lamp_s, lamp_w, lamp_walk;
    logic       fault;
    logic [2:0] fault_code;

    int errors = 0;
    int checks = 0;

    traffic_conflict_monitor #(
        .FILT_CYC    (2),
        .STUCK_CYC   (20),
        .BLINK_HALF  (4),
        .RECOVER_CYC (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .led_n_in    (led_n_in),
        .led_e_in    (led_e_in),
        .led_s_in    (led_s_in),
        .led_w_in    (led_w_in),
        .led_walk_in (led_walk_in),
        .clear_fault (clear_fault),
        .lamp_n      (lamp_n),
        .lamp_e      (lamp_e),
        .lamp_s      (lamp_s),
        .lamp_w      (lamp_w),
        .lamp_walk   (lamp_walk),
        .fault       (fault),
        .fault_code  (fault_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land 1 time unit after the edge.
    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_in(input logic [2:0] n, e, s, w, wk);
        led_n_in    = n;
        led_e_in    = e;
        led_s_in    = s;
        led_w_in    = w;
        led_walk_in = wk;
    endtask

    task automatic chk_status(input string tag, input logic f, input logic [2:0] code);
        check({tag, "_fault"}, {31'd0, fault}, {31'd0, f});
        check({tag, "_code"}, {29'd0, fault_code}, {29'd0, code});
    endtask

    task automatic chk_lamps(input string tag, input logic [2:0] n, e, s, w, wk);
        check({tag, "_n"},    {29'd0, lamp_n},    {29'd0, n});
        check({tag, "_e"},    {29'd0, lamp_e},    {29'd0, e});
        check({tag, "_s"},    {29'd0, lamp_s},    {29'd0, s});
        check({tag, "_w"},    {29'd0, lamp_w},    {29'd0, w});
        check({tag, "_walk"}, {29'd0, lamp_walk}, {29'd0, wk});
    endtask

    initial begin
        rst_n       = 1'b0;
        clear_fault = 1'b0;
        set_in(R, R, R, R, R);
        step(2);
        chk_lamps("reset", R, R, R, R, R);
        chk_status("reset", 1'b0, 3'd0);
        rst_n = 1'b1;

        // Legal north cycle and a walk phase pass straight through one cycle later.
        set_in(G, R, R, R, R); step(); chk_lamps("pass_ngrn", G, R, R, R, R);
        set_in(Y, R, R, R, R); step(); chk_lamps("pass_nyel", Y, R, R, R, R);
        set_in(R, R, R, R, R); step(); chk_lamps("pass_nred", R, R, R, R, R);
        set_in(R, R, R, R, G); step(); chk_lamps("pass_walk", R, R, R, R, G);
        set_in(R, R, R, R, Y); step();
        set_in(R, R, R, R, R); step(); chk_status("pass_end", 1'b0, 3'd0);

        // Single-cycle illegal encoding is filtered out.
        set_in(R, 3'b011, R, R, R); step();
        chk_lamps("glitch", R, 3'b011, R, R, R);
        chk_status("glitch", 1'b0, 3'd0);
        set_in(R, R, R, R, R); step(); chk_status("glitch_after1", 1'b0, 3'd0);
        step(); chk_status("glitch_after2", 1'b0, 3'd0);

        // Conflicting greens held two cycles.
        set_in(G, G, R, R, R); step();
        chk_status("conf_c1", 1'b0, 3'd0);
        chk_lamps("conf_c1", G, G, R, R, R);
        step();
        chk_status("conf_fire", 1'b1, 3'd2);
        chk_lamps("flash_f0", R, R, R, R, R);
        step(3); chk_lamps("flash_f3", R, R, R, R, R);
        step();  chk_lamps("flash_f4", O, O, O, O, R);
        step(3); chk_lamps("flash_f7", O, O, O, O, R);
        step();  chk_lamps("flash_f8", R, R, R, R, R);

        // Clear refused while walk and a road are both green.
        set_in(G, R, R, R, G); clear_fault = 1'b1; step(); clear_fault = 1'b0;
        chk_status("clr_refused", 1'b1, 3'd2);

        // Legal clear, then illegal code during the last recovery cycle pre-empts MON.
        set_in(Y, Y, R, R, Y); clear_fault = 1'b1; step(); clear_fault = 1'b0;
        chk_status("rec_r0", 1'b1, 3'd2);
        chk_lamps("rec_r0", R, R, R, R, R);
        step();
        set_in(3'b111, Y, R, R, Y);
        chk_status("rec_r1", 1'b1, 3'd2);
        step();
        chk_status("rec_r2", 1'b1, 3'd2);
        step();
        chk_status("rec_enc_fire", 1'b1, 3'd1);

        // Reset mid-flash.
        rst_n = 1'b0; set_in(R, R, R, R, R); step(); rst_n = 1'b1;
        chk_lamps("rst_flash", R, R, R, R, R);
        chk_status("rst_flash", 1'b0, 3'd0);
        set_in(G, R, R, R, R); step(); chk_lamps("rst_pass", G, R, R, R, R);
        set_in(Y, R, R, R, R); step();
        set_in(R, R, R, R, R); step();

        // South green -> red without yellow.
        set_in(R, R, G, R, R); step();
        chk_status("skip_pre", 1'b0, 3'd0);
        chk_lamps("skip_pre", R, R, G, R, R);
        set_in(R, R, R, R, R); step();
        chk_status("skip_fire", 1'b1, 3'd3);
        check("skip_lamp_s", {29'd0, lamp_s}, {29'd0, R});

        // Clear with frozen legal inputs; recovery completes, then the re-armed stuck timer fires.
        clear_fault = 1'b1; step(); clear_fault = 1'b0;
        chk_status("rec2_r0", 1'b1, 3'd3);
        step(2);
        chk_status("rec2_r2", 1'b1, 3'd3);
        step();
        chk_status("rec2_mon", 1'b0, 3'd0);
        step(16);
        chk_status("stuck_pre", 1'b0, 3'd0);
        step();
        chk_status("stuck_fire", 1'b1, 3'd4);

        // Clear with walk green; lamps stay solid red for three cycles, then pass through.
        set_in(R, R, R, R, G); clear_fault = 1'b1; step(); clear_fault = 1'b0;
        chk_status("rec3_r0", 1'b1, 3'd4);
        step(2);
        chk_lamps("rec3_r2", R, R, R, R, R);
        check("rec3_r2_fault", {31'd0, fault}, 32'd1);
        step();
        chk_status("rec3_mon", 1'b0, 3'd0);
        chk_lamps("rec3_mon", R, R, R, R, G);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
